// File: rtl/pwm_mc_pkg.sv
// Shared constants for the multi-channel PWM: mode encoding, defaults and
// the counter direction type used by the timebase.
package pwm_mc_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_mc_channel.sv
// One PWM channel: compare against the shared counter and drive registered
// complementary outputs. Dead-time insertion is built only with PWM_MC_DEAD_TIME_EN.
module pwm_mc_channel
  import pwm_mc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] dead_time,
  input  logic             enable,
  output logic             pwm_h,
  output logic             pwm_l
);

  logic raw;
  assign raw = (cnt < duty);

`ifdef PWM_MC_DEAD_TIME_EN
  logic             raw_q;
  logic [CNT_W-1:0] dt_cnt;
  logic             raw_edge;

  assign raw_edge = (raw != raw_q);

  // dt_cnt holds the remaining blanked cycles after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q  <= 1'b0;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (!enable) begin
      raw_q  <= raw;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      raw_q <= raw;
      if (raw_edge && (dead_time != '0)) begin
        dt_cnt <= dead_time - CNT_W'(1);
        pwm_h  <= 1'b0;
        pwm_l  <= 1'b0;
      end else if (dt_cnt != '0) begin
        if (cnt_en) dt_cnt <= dt_cnt - CNT_W'(1);
        pwm_h <= 1'b0;
        pwm_l <= 1'b0;
      end else begin
        pwm_h <= raw;
        pwm_l <= ~raw;
      end
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^{cnt_en, dead_time};

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <= enable & raw;
      pwm_l <= enable & ~raw;
    end
  end
`endif

endmodule

// File: rtl/pwm_mc.sv
// Multi-channel PWM: shared sawtooth/triangle timebase with shadowed settings
// loaded at each period start. Optional dead-time via PWM_MC_DEAD_TIME_EN.
module pwm_mc
  import pwm_mc_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnt_en,
  input  logic                  mode,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [CNT_W-1:0]      dead_time,
  input  logic [N_CH-1:0]       pwm_enable,
  output logic [N_CH-1:0]       pwm_h,
  output logic [N_CH-1:0]       pwm_l,
  output logic                  zero_trigger,
  output logic                  ovf_trigger
);

  logic [CNT_W-1:0]      cnt, cnt_nxt;
  dir_e                  dir, dir_nxt;
  logic                  mode_a;
  logic [CNT_W-1:0]      period_a;
  logic [N_CH*CNT_W-1:0] duty_a;
  logic [CNT_W-1:0]      dead_a;

  // At a period start the fresh inputs are already in force, so the first
  // counter step and compare of the new period use them.
  logic                  period_start;
  logic                  eff_mode;
  logic [CNT_W-1:0]      eff_period;
  logic [N_CH*CNT_W-1:0] eff_duty;
  logic [CNT_W-1:0]      eff_dead;

  assign period_start = cnt_en && (cnt == '0);
  assign eff_mode     = period_start ? mode      : mode_a;
  assign eff_period   = period_start ? period    : period_a;
  assign eff_duty     = period_start ? duty      : duty_a;
  assign eff_dead     = period_start ? dead_time : dead_a;

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (cnt_en) begin
      if (eff_period == '0) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end else if (eff_mode == MODE_SAW) begin
        dir_nxt = DIR_UP;
        cnt_nxt = (cnt >= eff_period) ? '0 : cnt + CNT_W'(1);
      end else if ((dir == DIR_UP) || (cnt == '0)) begin
        if (cnt >= eff_period) begin
          cnt_nxt = eff_period - CNT_W'(1);
          dir_nxt = (eff_period == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          dir_nxt = DIR_UP;
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
        dir_nxt = (cnt == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_a       <= mode;
      period_a     <= period;
      duty_a       <= duty;
      dead_a       <= dead_time;
      zero_trigger <= 1'b0;
      ovf_trigger  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
      if (period_start) begin
        mode_a   <= mode;
        period_a <= period;
        duty_a   <= duty;
        dead_a   <= dead_time;
      end
      zero_trigger <= cnt_en && (cnt == '0);
      ovf_trigger  <= cnt_en && (cnt == eff_period);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_mc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cnt_en    (cnt_en),
      .cnt       (cnt),
      .duty      (eff_duty[k*CNT_W +: CNT_W]),
      .dead_time (eff_dead),
      .enable    (pwm_enable[k]),
      .pwm_h     (pwm_h[k]),
      .pwm_l     (pwm_l[k])
    );
  end

endmodule
